// File: rtl/sram_stream_reader.sv
// Paced SRAM playback: prefetches sequential words into a small FIFO and
// releases one sample per rate_div+1 clocks, one-shot or looped.
module sram_stream_reader #(
  parameter int aw    = 19,
  parameter int dw    = 8,
  parameter int depth = 4,
  parameter int divw  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic [aw-1:0]   base_addr,
  input  logic [aw-1:0]   length,
  input  logic            loop,
  input  logic [divw-1:0] rate_div,
  output logic [aw-1:0]   req_addr,
  output logic            req_en,
  input  logic            req_busy,
  input  logic            rd_valid,
  input  logic [dw-1:0]   rd_data,
  output logic [dw-1:0]   sample,
  output logic            sample_stb,
  output logic            running,
  output logic            done,
  output logic            underrun
);
  localparam int pw = (depth > 1) ? $clog2(depth) : 1;
  localparam int cw = pw + 1;
  localparam logic [cw-1:0] full = cw'(depth);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_t;
  state_t state, state_n;

  logic [aw-1:0]            base_q, len_q, addr_n, remaining, rem_n;
  logic                     loop_q;
  logic [cw-1:0]            cnt, cnt_n, outstanding, out_n;
  logic [cw:0]              used_n;
  logic [pw-1:0]            wp, rp;
  logic [depth-1:0][dw-1:0] mem;
  logic [divw-1:0]          div_cnt;
  logic                     acc, push, tick, pop, flush, launch, fin, go_run;

  always_comb begin
    acc    = req_en && !req_busy;
    flush  = stop && (state == PRIME || state == RUN);
    launch = (state == IDLE) && start;
    push   = rd_valid && (state == PRIME || state == RUN) && !stop;
    tick   = (state == RUN) && (div_cnt == rate_div);
    pop    = tick && !stop && (cnt != '0);

    addr_n = req_addr;
    rem_n  = remaining;
    if (acc) begin
      if (remaining == aw'(1) && loop_q) begin
        addr_n = base_q;
        rem_n  = len_q;
      end else begin
        addr_n = req_addr + aw'(1);
        rem_n  = remaining - aw'(1);
      end
    end

    // Reads accepted while stopping still come back and must be counted off.
    out_n = outstanding;
    if (acc && !rd_valid)
      out_n = outstanding + cw'(1);
    else if (!acc && rd_valid && outstanding != '0)
      out_n = outstanding - cw'(1);

    cnt_n = cnt;
    if (push && !pop)
      cnt_n = cnt + cw'(1);
    else if (pop && !push)
      cnt_n = cnt - cw'(1);

    fin    = pop && !loop_q && rem_n == '0 && out_n == '0 && cnt_n == '0;
    go_run = (cnt == full) || (remaining == '0 && outstanding == '0);

    state_n = state;
    case (state)
      IDLE:    if (start && length != '0) state_n = PRIME;
      PRIME:   if (flush) state_n = FLUSH; else if (go_run) state_n = RUN;
      RUN:     if (flush) state_n = FLUSH; else if (fin) state_n = IDLE;
      FLUSH:   if (out_n == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (flush || launch) cnt_n = '0;
    if (launch) begin
      addr_n = base_addr;
      rem_n  = length;
      out_n  = '0;
    end
    used_n = {1'b0, cnt_n} + {1'b0, out_n};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_addr    <= '0;
      remaining   <= '0;
      outstanding <= '0;
      cnt         <= '0;
      wp          <= '0;
      rp          <= '0;
      div_cnt     <= '0;
      base_q      <= '0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      req_en      <= 1'b0;
      running     <= 1'b0;
      sample      <= '0;
      sample_stb  <= 1'b0;
      done        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_n;
      req_addr    <= addr_n;
      remaining   <= rem_n;
      outstanding <= out_n;
      cnt         <= cnt_n;
      // Request enable is decided from next-cycle occupancy so it can be a flop.
      req_en      <= (state_n == PRIME || state_n == RUN) && rem_n != '0 &&
                     (used_n < {1'b0, full});
      running     <= (state_n != IDLE);
      sample_stb  <= pop;
      underrun    <= tick && !stop && (cnt == '0);
      done        <= fin || (launch && length == '0);
      div_cnt     <= (state == RUN && !tick) ? div_cnt + divw'(1) : '0;
      if (push) begin
        mem[wp] <= rd_data;
        wp      <= wp + pw'(1);
      end
      if (pop) begin
        sample <= mem[rp];
        rp     <= rp + pw'(1);
      end
      if (flush || launch) begin
        wp <= '0;
        rp <= '0;
      end
      if (launch) begin
        base_q <= base_addr;
        len_q  <= length;
        loop_q <= loop;
      end
    end
  end
endmodule
